// File: rtl/uart_relay_stage.sv
`default_nettype none
// ============================================================================
// Module      : uart_relay_stage
// Description : Buffers bytes from the UART receive side, with an optional
//               single-byte substitution, and replays them on the transmit side.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_relay_stage #(
    parameter int NUM_DATA_BITS   = 8,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       relay_enable,
    input  logic                       subst_enable,
    input  logic [NUM_DATA_BITS-1:0]   match_byte,
    input  logic [NUM_DATA_BITS-1:0]   replace_byte,
    input  logic                       rx_new_data_ready,
    input  logic [NUM_DATA_BITS-1:0]   rx_data,
    input  logic                       tx_write_ready,
    output logic                       tx_select,
    output logic                       tx_start,
    output logic [NUM_DATA_BITS-1:0]   tx_data,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       overflow
);

    localparam int                     c_DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] c_FULL = (FIFO_ADDR_WIDTH+1)'(c_DEPTH);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD      = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_next;
    logic                       w_tx_start;

    logic                       r_rx_q;
    logic                       r_rx_qq;
    logic [NUM_DATA_BITS-1:0]   r_mem [c_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_count;
    logic                       r_tx_select;
    logic [NUM_DATA_BITS-1:0]   r_tx_data;
    logic                       r_overflow;

    logic                       w_capture;
    logic                       w_in_idle;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_flush;
    logic                       w_push;
    logic                       w_drop;
    logic [NUM_DATA_BITS-1:0]   w_wr_byte;

    // Edge is taken between the two registered copies, so a byte lands one
    // cycle after the level is first seen.
    assign w_capture = r_rx_q & ~r_rx_qq & r_tx_select;
    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = w_in_idle & ~w_empty & r_tx_select & relay_enable;
    assign w_flush   = w_in_idle & ~w_empty & ~relay_enable;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts it.
    assign w_push    = w_capture & ~w_flush & (~w_full | w_pop);
    assign w_drop    = w_capture & ~w_flush & w_full & ~w_pop;
    assign w_wr_byte = (subst_enable && (rx_data == match_byte)) ? replace_byte : rx_data;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_start   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (tx_write_ready) begin
                    w_state_next = c_ST_START;
                end
            end
            c_ST_START: begin
                w_tx_start   = 1'b1;
                w_state_next = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (!tx_write_ready) begin
                    w_state_next = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (tx_write_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= w_wr_byte;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_rx_q      <= 1'b0;
            r_rx_qq     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tx_select <= 1'b0;
            r_tx_data   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_q  <= rx_new_data_ready;
            r_rx_qq <= r_rx_q;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_flush) begin
                r_count <= '0;
            end else if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end

            // Select only moves between bytes; clearing waits for the flush.
            if (w_in_idle) begin
                if (relay_enable) begin
                    r_tx_select <= 1'b1;
                end else if (w_empty) begin
                    r_tx_select <= 1'b0;
                end
            end
        end
    end

    assign tx_select  = r_tx_select;
    assign tx_start   = w_tx_start;
    assign tx_data    = r_tx_data;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_relay_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_relay_stage
// Description : Directed self-checking bench for uart_relay_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_relay_stage;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       relay_enable = 1'b0;
    logic       subst_enable = 1'b0;
    logic [7:0] match_byte = 8'h00;
    logic [7:0] replace_byte = 8'h00;
    logic       rx_new_data_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_write_ready;
    logic       tx_select;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;

    logic       force_busy = 1'b0;
    int         busy_cnt = 0;

    int         checks = 0;
    int         failures = 0;

    int         cyc = 0;
    logic [7:0] pq_data [$];
    int         pq_cyc [$];
    int         max_count = 0;
    int         min_gap = 1000;
    int         last_pulse = -100;
    int         doubles = 0;
    logic       prev_start = 1'b0;

    uart_relay_stage #(
        .NUM_DATA_BITS   (8),
        .FIFO_ADDR_WIDTH (4)
    ) dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .relay_enable      (relay_enable),
        .subst_enable      (subst_enable),
        .match_byte        (match_byte),
        .replace_byte      (replace_byte),
        .rx_new_data_ready (rx_new_data_ready),
        .rx_data           (rx_data),
        .tx_write_ready    (tx_write_ready),
        .tx_select         (tx_select),
        .tx_start          (tx_start),
        .tx_data           (tx_data),
        .fifo_count        (fifo_count),
        .overflow          (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Controller stand-in: busy for two cycles starting the cycle after tx_start.
    assign tx_write_ready = ~force_busy && (busy_cnt == 0);
    always @(posedge sys_clk) begin
        if (!rst) begin
            busy_cnt <= 0;
        end else if (tx_start === 1'b1) begin
            busy_cnt <= 2;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (rst === 1'b1) begin
            if (tx_start === 1'b1) begin
                if (prev_start) doubles = doubles + 1;
                if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
                last_pulse = cyc;
                pq_data.push_back(tx_data);
                pq_cyc.push_back(cyc);
            end
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            prev_start = (tx_start === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data           = b;
        rx_new_data_ready = 1'b1;
        tick(2);
        rx_new_data_ready = 1'b0;
        tick(gap);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pq_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            relay_enable      = i[0];
            subst_enable      = ~i[0];
            rx_new_data_ready = i[0];
            rx_data           = 8'($urandom);
            match_byte        = 8'($urandom);
            replace_byte      = 8'($urandom);
            force_busy        = ~i[0];
            tick(1);
            obs = {tx_select, tx_start, tx_data, fifo_count, overflow};
            checks++;
            if (obs !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold[%0d] outputs=%04h expected=0000", i, obs);
            end
        end
        relay_enable = 1'b0; subst_enable = 1'b0; rx_new_data_ready = 1'b0;
        rx_data = 8'h00; match_byte = 8'h00; replace_byte = 8'h00; force_busy = 1'b0;
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        int c0;
        int base;
        base = pq_data.size();
        relay_enable = 1'b1;
        tick(2);
        checks++;
        if (tx_select !== 1'b1) begin
            failures++;
            $display("FAIL single_select got=%b expected=1", tx_select);
        end
        c0 = cyc;
        rx_data = 8'hA5;
        rx_new_data_ready = 1'b1;
        tick(2);
        checks++;
        if (fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL single_count_after_capture got=%0d expected=1", fifo_count);
        end
        rx_new_data_ready = 1'b0;
        tick(1);
        checks++;
        if (fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL single_count_after_pop got=%0d expected=0", fifo_count);
        end
        wait_pulses(base + 1, 20);
        tick(10);
        checks++;
        if (pq_data.size() !== base + 1) begin
            failures++;
            $display("FAIL single_pulse_count got=%0d expected=%0d", pq_data.size() - base, 1);
        end
        checks++;
        if (pq_data[base] !== 8'hA5) begin
            failures++;
            $display("FAIL single_data got=%02h expected=a5", pq_data[base]);
        end
        checks++;
        if (pq_cyc[base] !== c0 + 5) begin
            failures++;
            $display("FAIL single_latency got_cycle=%0d expected_cycle=%0d", pq_cyc[base], c0 + 5);
        end
    endtask

    task automatic test_subst();
        int base;
        base = pq_data.size();
        subst_enable = 1'b1;
        match_byte   = 8'h13;
        replace_byte = 8'h37;
        send_byte(8'h13, 2);
        send_byte(8'h14, 2);
        subst_enable = 1'b0;
        send_byte(8'h13, 2);
        wait_pulses(base + 3, 80);
        checks++;
        if (pq_data.size() !== base + 3) begin
            failures++;
            $display("FAIL subst_pulse_count got=%0d expected=3", pq_data.size() - base);
        end
        checks++;
        if (pq_data[base] !== 8'h37) begin
            failures++;
            $display("FAIL subst_replaced got=%02h expected=37", pq_data[base]);
        end
        checks++;
        if (pq_data[base+1] !== 8'h14) begin
            failures++;
            $display("FAIL subst_passthru got=%02h expected=14", pq_data[base+1]);
        end
        checks++;
        if (pq_data[base+2] !== 8'h13) begin
            failures++;
            $display("FAIL subst_disabled got=%02h expected=13", pq_data[base+2]);
        end
        tick(10);
    endtask

    task automatic test_overflow();
        int base;
        base = pq_data.size();
        // Park the FSM in WAIT_DONE so every captured byte stays in the FIFO.
        send_byte(8'hEE, 2);
        wait_pulses(base + 1, 20);
        force_busy = 1'b1;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_initially_clear got=%b expected=0", overflow);
        end
        for (int i = 0; i < 17; i++) send_byte(8'(i), 2);
        checks++;
        if (fifo_count !== 5'd16) begin
            failures++;
            $display("FAIL ovf_count got=%0d expected=16", fifo_count);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b expected=1", overflow);
        end
        force_busy = 1'b0;
        wait_pulses(base + 17, 400);
        tick(40);
        checks++;
        if (pq_data.size() !== base + 17) begin
            failures++;
            $display("FAIL ovf_pulse_count got=%0d expected=17", pq_data.size() - base);
        end
        checks++;
        if (pq_data[base] !== 8'hEE) begin
            failures++;
            $display("FAIL ovf_primer got=%02h expected=ee", pq_data[base]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (pq_data[base+1+i] !== 8'(i)) begin
                failures++;
                $display("FAIL ovf_order[%0d] got=%02h expected=%02h", i, pq_data[base+1+i], 8'(i));
            end
        end
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL ovf_after_drain overflow=%b count=%0d expected overflow=1 count=0", overflow, fifo_count);
        end
    endtask

    task automatic test_wrap();
        int base;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_reset_clears_overflow got=%b expected=0", overflow);
        end
        base = pq_data.size();
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            force_busy = (i % 5 == 1);
            send_byte(8'(i * 7 + 3), 6);
        end
        force_busy = 1'b0;
        wait_pulses(base + 40, 400);
        tick(20);
        checks++;
        if (pq_data.size() !== base + 40) begin
            failures++;
            $display("FAIL wrap_pulse_count got=%0d expected=40", pq_data.size() - base);
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (pq_data[base+i] !== 8'(i * 7 + 3)) begin
                failures++;
                $display("FAIL wrap_order[%0d] got=%02h expected=%02h", i, pq_data[base+i], 8'(i * 7 + 3));
            end
        end
        checks++;
        if (max_count > 16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_occupancy max=%0d overflow=%b expected max<=16 overflow=0", max_count, overflow);
        end
    endtask

    task automatic test_disable();
        int base;
        tick(10);
        base = pq_data.size();
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i), 2);
        checks++;
        if (fifo_count !== 5'd3) begin
            failures++;
            $display("FAIL dis_queued got=%0d expected=3", fifo_count);
        end
        force_busy = 1'b0;
        wait_pulses(base + 1, 20);
        relay_enable = 1'b0;
        tick(20);
        checks++;
        if (pq_data.size() !== base + 1) begin
            failures++;
            $display("FAIL dis_pulse_count got=%0d expected=1", pq_data.size() - base);
        end
        checks++;
        if (pq_data[base] !== 8'h51) begin
            failures++;
            $display("FAIL dis_inflight_data got=%02h expected=51", pq_data[base]);
        end
        checks++;
        if (fifo_count !== 5'd0 || tx_select !== 1'b0) begin
            failures++;
            $display("FAIL dis_flushed count=%0d select=%b expected count=0 select=0", fifo_count, tx_select);
        end
        send_byte(8'h99, 2);
        tick(20);
        checks++;
        if (fifo_count !== 5'd0 || pq_data.size() !== base + 1) begin
            failures++;
            $display("FAIL dis_no_capture count=%0d pulses=%0d expected count=0 pulses=1", fifo_count, pq_data.size() - base);
        end
    endtask

    task automatic test_spacing();
        checks++;
        if (doubles !== 0) begin
            failures++;
            $display("FAIL spacing_back_to_back got=%0d expected=0", doubles);
        end
        checks++;
        if (min_gap < 5) begin
            failures++;
            $display("FAIL spacing_min_gap got=%0d expected>=5", min_gap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_subst();
        test_overflow();
        test_wrap();
        test_disable();
        test_spacing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
